// File: rtl/pwm_duty_generator.sv
// PWM generator: duty (1/DUTY_SCALE units) is turned into a high-cycle count by a
// serial restoring divider; the new period/high_count is swapped in only on a period boundary.
module pwm_duty_generator #(
  parameter int DATAWIDTH  = 30,
  parameter int DUTY_SCALE = 10000
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [DATAWIDTH-1:0] cfg_period,
  input  logic [13:0]          cfg_duty,
  output logic                 cfg_error,
  output logic                 pwm_out,
  output logic                 period_start,
  output logic                 active,
  output logic [DATAWIDTH-1:0] high_count
);

  localparam int PW = DATAWIDTH + 14;
  // remainder < DUTY_SCALE; one extra bit holds the shifted-in partial remainder
  localparam int RW = $clog2(DUTY_SCALE) + 1;
  localparam int IW = $clog2(PW);

  localparam logic [IW-1:0] LAST_IT  = IW'(PW - 1);
  localparam logic [RW-1:0] DS_R     = RW'(DUTY_SCALE);
  localparam logic [13:0]   DUTY_MAX = 14'(DUTY_SCALE);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_PEND = 2'd3;

  logic [1:0]           state;
  logic [PW-1:0]        prod_q;
  logic [PW-1:0]        dvd;
  logic [PW-1:0]        dvd_nxt;
  logic [RW-2:0]        rem;
  logic [RW-2:0]        rem_nxt;
  logic [RW-1:0]        rem_sh;
  logic                 q_bit;
  logic [IW-1:0]        it;
  logic [DATAWIDTH-1:0] pend_period;
  logic [DATAWIDTH-1:0] period_q;
  logic [DATAWIDTH-1:0] cnt;
  logic                 hs;
  logic                 cfg_bad;
  logic                 wrap;
  logic                 apply;

  assign cfg_ready    = (state == S_IDLE);
  assign hs           = cfg_valid && cfg_ready;
  assign cfg_bad      = (cfg_period < DATAWIDTH'(2)) || (cfg_duty > DUTY_MAX);
  assign wrap         = (cnt == period_q - DATAWIDTH'(1));
  // idle output starts at once; a running waveform only changes at its wrap
  assign apply        = (state == S_PEND) && (!active || wrap);
  assign period_start = active && (cnt == '0);

  // One restoring step: the dividend register shifts left and collects quotient bits,
  // so after PW steps it holds the quotient.
  always_comb begin
    rem_sh  = {rem, dvd[PW-1]};
    q_bit   = (rem_sh >= DS_R);
    rem_nxt = q_bit ? (rem_sh[RW-2:0] - DS_R[RW-2:0]) : rem_sh[RW-2:0];
    dvd_nxt = {dvd[PW-2:0], q_bit};
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= S_IDLE;
      cfg_error   <= 1'b0;
      prod_q      <= '0;
      pend_period <= '0;
      dvd         <= '0;
      rem         <= '0;
      it          <= '0;
    end else begin
      cfg_error <= 1'b0;
      case (state)
        S_IDLE: begin
          if (hs && cfg_bad) begin
            cfg_error <= 1'b1;
          end else if (hs) begin
            prod_q      <= PW'(cfg_period) * PW'(cfg_duty);
            pend_period <= cfg_period;
            state       <= S_MUL;
          end
        end
        S_MUL: begin
          dvd   <= prod_q;
          rem   <= '0;
          it    <= '0;
          state <= S_DIV;
        end
        S_DIV: begin
          dvd <= dvd_nxt;
          rem <= rem_nxt;
          it  <= it + IW'(1);
          if (it == LAST_IT) state <= S_PEND;
        end
        S_PEND: begin
          if (apply) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      active     <= 1'b0;
      period_q   <= '0;
      high_count <= '0;
      cnt        <= '0;
      pwm_out    <= 1'b0;
    end else begin
      pwm_out <= active && (cnt < high_count);
      if (apply) begin
        active     <= 1'b1;
        period_q   <= pend_period;
        high_count <= dvd[DATAWIDTH-1:0];
        cnt        <= '0;
      end else if (active) begin
        cnt <= wrap ? '0 : cnt + DATAWIDTH'(1);
      end
    end
  end

endmodule
